// File: rtl/pong_pkg.sv
// Shared types and helpers for the multi-ball physics engine.
package pong_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_UPDATE = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   // Direction bits: dir = {x_dir, y_dir}; 1 means right / down.
   localparam logic S_LEFT  = 1'b0;
   localparam logic S_RIGHT = 1'b1;
   localparam logic S_UP    = 1'b0;
   localparam logic S_DOWN  = 1'b1;

   // Ball-state field widths that do not depend on the playfield.
   localparam int DIR_W = 2;
   localparam int HIT_W = 16;

   // Width of an index/counter that must hold n distinct values (min 1 bit).
   function automatic int idx_width(input int n);
      return ($clog2(n) > 0) ? $clog2(n) : 1;
   endfunction

   // Paddle overlap test on the pre-step y; additions only, so no underflow.
   function automatic logic hit_detect(input logic [HIT_W-1:0] y,
                                       input logic [HIT_W-1:0] pad_y,
                                       input logic [HIT_W-1:0] pad_h,
                                       input logic [HIT_W-1:0] box);
      return (y < pad_y + pad_h) && (y + box > pad_y);
   endfunction

endpackage

// File: rtl/ball_step_unit.sv
// Combinational single-ball step: wall/paddle bounce, miss detection, speed ramp.
module ball_step_unit
   import pong_pkg::*;
#(
   parameter int X_MAX         = 640,
   parameter int Y_MIN         = 20,
   parameter int Y_MAX         = 480,
   parameter int BOX           = 4,
   parameter int PADDLE_X      = 4,
   parameter int PADDLE_OFFSET = 2,
   parameter int PADDLE_Y      = 15,
   parameter int MAX_RATE      = 15,
   parameter int ACCEL_FRAMES  = 30,
   parameter int XW            = 11,
   parameter int YW            = 10,
   parameter int RW            = 5,
   parameter int AW            = 5
) (
   input  logic [XW-1:0]    cur_x,
   input  logic [YW-1:0]    cur_y,
   input  logic [DIR_W-1:0] cur_dir,
   input  logic [RW-1:0]    cur_rate,
   input  logic [AW-1:0]    cur_ramp,
   input  logic             cur_active,
   input  logic [YW-1:0]    left_paddle_y,
   input  logic [YW-1:0]    right_paddle_y,
   output logic [XW-1:0]    nxt_x,
   output logic [YW-1:0]    nxt_y,
   output logic [DIR_W-1:0] nxt_dir,
   output logic [RW-1:0]    nxt_rate,
   output logic [AW-1:0]    nxt_ramp,
   output logic             nxt_active,
   output logic             contact,
   output logic             lhs_scored,
   output logic             rhs_scored
);

   localparam int X_MIN = PADDLE_X + PADDLE_OFFSET;

   int   x_i, y_i, r_i, a_i;
   logic left_hit, right_hit;

   assign x_i = int'(cur_x);
   assign y_i = int'(cur_y);
   assign r_i = int'(cur_rate);
   assign a_i = int'(cur_ramp);

   assign left_hit  = hit_detect(HIT_W'(cur_y), HIT_W'(left_paddle_y),
                                 HIT_W'(PADDLE_Y), HIT_W'(BOX));
   assign right_hit = hit_detect(HIT_W'(cur_y), HIT_W'(right_paddle_y),
                                 HIT_W'(PADDLE_Y), HIT_W'(BOX));

   // Next ball state; contact is a single OR so a corner gives one pulse.
   always_comb begin
      nxt_x      = cur_x;
      nxt_y      = cur_y;
      nxt_dir    = cur_dir;
      nxt_rate   = cur_rate;
      nxt_ramp   = cur_ramp;
      nxt_active = cur_active;
      contact    = 1'b0;
      lhs_scored = 1'b0;
      rhs_scored = 1'b0;

      if (cur_dir[0] == S_DOWN) begin
         if (y_i + r_i >= Y_MAX - BOX) begin
            nxt_y      = YW'(Y_MAX - BOX);
            nxt_dir[0] = S_UP;
            contact    = 1'b1;
         end else begin
            nxt_y = YW'(y_i + r_i);
         end
      end else begin
         if (y_i < Y_MIN + r_i) begin
            nxt_y      = YW'(Y_MIN);
            nxt_dir[0] = S_DOWN;
            contact    = 1'b1;
         end else begin
            nxt_y = YW'(y_i - r_i);
         end
      end

      if (cur_dir[1] == S_LEFT) begin
         if (x_i < X_MIN + r_i) begin
            if (left_hit) begin
               nxt_x      = XW'(X_MIN);
               nxt_dir[1] = S_RIGHT;
               contact    = 1'b1;
            end else begin
               nxt_active = 1'b0;
               rhs_scored = 1'b1;
            end
         end else begin
            nxt_x = XW'(x_i - r_i);
         end
      end else begin
         if (x_i + r_i > X_MAX - BOX) begin
            if (right_hit) begin
               nxt_x      = XW'(X_MAX - BOX);
               nxt_dir[1] = S_LEFT;
               contact    = 1'b1;
            end else begin
               nxt_active = 1'b0;
               lhs_scored = 1'b1;
            end
         end else begin
            nxt_x = XW'(x_i + r_i);
         end
      end

      if (a_i == ACCEL_FRAMES - 1) begin
         nxt_ramp = '0;
         if (r_i < MAX_RATE) nxt_rate = RW'(r_i + 1);
      end else begin
         nxt_ramp = AW'(a_i + 1);
      end
   end

endmodule

// File: rtl/multi_ball_engine.sv
// Time-multiplexed physics engine: one ball stepped per clk during an update pass.
//
// Handshake: a serve is taken on a clk edge where serve && serve_ready && enable
// and the addressed ball is out of play; otherwise the request is dropped (no hold).
module multi_ball_engine
   import pong_pkg::*;
#(
   parameter int NUM_BALLS     = 4,
   parameter int X_MAX         = 640,
   parameter int Y_MIN         = 20,
   parameter int Y_MAX         = 480,
   parameter int BOX           = 4,
   parameter int PADDLE_X      = 4,
   parameter int PADDLE_OFFSET = 2,
   parameter int PADDLE_Y      = 15,
   parameter int RATE          = 1,
   parameter int MAX_RATE      = 15,
   parameter int ACCEL_FRAMES  = 30,
   localparam int IW = idx_width(NUM_BALLS),
   localparam int XW = $clog2(X_MAX) + 1,
   localparam int YW = $clog2(Y_MAX) + 1,
   localparam int RW = $clog2(MAX_RATE) + 1
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          enable,
   input  logic          frameTick,
   input  logic          serve,
   input  logic [IW-1:0] serve_idx,
   input  logic [1:0]    serve_dir,
   output logic          serve_ready,
   input  logic [YW-1:0] left_paddle_y,
   input  logic [YW-1:0] right_paddle_y,
   input  logic [IW-1:0] rd_idx,
   output logic [XW-1:0] rd_x,
   output logic [XW-1:0] rd_old_x,
   output logic [YW-1:0] rd_y,
   output logic [YW-1:0] rd_old_y,
   output logic          rd_active,
   output logic [RW-1:0] rd_rate,
   output logic          busy,
   output logic          update_done,
   output logic          overrun,
   output logic          lhs_scored,
   output logic          rhs_scored,
   output logic          boundary_contact,
   output logic [IW-1:0] event_idx,
   output logic [1:0]    dbg_state
);

   localparam int AW = idx_width(ACCEL_FRAMES);

   state_t state_q, state_d;
   logic [IW-1:0] idx_q;

   logic [XW-1:0]    x_q     [NUM_BALLS];
   logic [XW-1:0]    old_x_q [NUM_BALLS];
   logic [YW-1:0]    y_q     [NUM_BALLS];
   logic [YW-1:0]    old_y_q [NUM_BALLS];
   logic [DIR_W-1:0] dir_q   [NUM_BALLS];
   logic [RW-1:0]    rate_q  [NUM_BALLS];
   logic [AW-1:0]    ramp_q  [NUM_BALLS];
   logic             active_q[NUM_BALLS];

   logic [XW-1:0]    s_x;
   logic [YW-1:0]    s_y;
   logic [DIR_W-1:0] s_dir;
   logic [RW-1:0]    s_rate;
   logic [AW-1:0]    s_ramp;
   logic             s_active, s_contact, s_lhs, s_rhs;
   logic             step_en, serve_acc, last_ball;

   assign last_ball = (idx_q == IW'(NUM_BALLS - 1));
   assign step_en   = (state_q == S_UPDATE) && enable && active_q[idx_q];
   assign serve_acc = serve && serve_ready && enable &&
                      (int'(serve_idx) < NUM_BALLS) && !active_q[serve_idx];

   ball_step_unit #(
      .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX), .BOX(BOX),
      .PADDLE_X(PADDLE_X), .PADDLE_OFFSET(PADDLE_OFFSET), .PADDLE_Y(PADDLE_Y),
      .MAX_RATE(MAX_RATE), .ACCEL_FRAMES(ACCEL_FRAMES),
      .XW(XW), .YW(YW), .RW(RW), .AW(AW)
   ) u_step (
      .cur_x(x_q[idx_q]), .cur_y(y_q[idx_q]), .cur_dir(dir_q[idx_q]),
      .cur_rate(rate_q[idx_q]), .cur_ramp(ramp_q[idx_q]), .cur_active(active_q[idx_q]),
      .left_paddle_y(left_paddle_y), .right_paddle_y(right_paddle_y),
      .nxt_x(s_x), .nxt_y(s_y), .nxt_dir(s_dir), .nxt_rate(s_rate),
      .nxt_ramp(s_ramp), .nxt_active(s_active),
      .contact(s_contact), .lhs_scored(s_lhs), .rhs_scored(s_rhs)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // FSM next state; enable low stalls the pass in place.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (enable && frameTick) state_d = S_UPDATE;
         S_UPDATE: if (enable && last_ball) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy        = (state_q != S_IDLE);
      update_done = (state_q == S_DONE);
      serve_ready = (state_q == S_IDLE);
      dbg_state   = state_q;
   end

   // Ball pointer: cleared in IDLE, advances one ball per enabled UPDATE clk.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                                idx_q <= '0;
      else if (state_q != S_UPDATE)               idx_q <= '0;
      else if (enable) idx_q <= last_ball ? '0 : idx_q + IW'(1);
   end

   // Per-ball state: serves land in IDLE, steps in UPDATE, never the same clk.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_BALLS; i++) begin
            x_q[i]      <= XW'(X_MAX / 2);
            old_x_q[i]  <= XW'(X_MAX / 2);
            y_q[i]      <= YW'((Y_MIN + Y_MAX) / 2);
            old_y_q[i]  <= YW'((Y_MIN + Y_MAX) / 2);
            dir_q[i]    <= 2'b11;
            rate_q[i]   <= RW'(RATE);
            ramp_q[i]   <= '0;
            active_q[i] <= 1'b0;
         end
      end else if (serve_acc) begin
         x_q[serve_idx]      <= XW'(X_MAX / 2);
         old_x_q[serve_idx]  <= XW'(X_MAX / 2);
         y_q[serve_idx]      <= YW'((Y_MIN + Y_MAX) / 2);
         old_y_q[serve_idx]  <= YW'((Y_MIN + Y_MAX) / 2);
         dir_q[serve_idx]    <= serve_dir;
         rate_q[serve_idx]   <= RW'(RATE);
         ramp_q[serve_idx]   <= '0;
         active_q[serve_idx] <= 1'b1;
      end else if (step_en) begin
         old_x_q[idx_q]  <= x_q[idx_q];
         old_y_q[idx_q]  <= y_q[idx_q];
         x_q[idx_q]      <= s_x;
         y_q[idx_q]      <= s_y;
         dir_q[idx_q]    <= s_dir;
         rate_q[idx_q]   <= s_rate;
         ramp_q[idx_q]   <= s_ramp;
         active_q[idx_q] <= s_active;
      end
   end

   // Registered event pulses, tagged with the ball that produced them.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         boundary_contact <= 1'b0;
         lhs_scored       <= 1'b0;
         rhs_scored       <= 1'b0;
         event_idx        <= '0;
      end else begin
         boundary_contact <= step_en && s_contact;
         lhs_scored       <= step_en && s_lhs;
         rhs_scored       <= step_en && s_rhs;
         if (step_en) event_idx <= idx_q;
      end
   end

   // Sticky flag: a tick landed while a pass was running and was dropped.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                          overrun <= 1'b0;
      else if (enable && frameTick && busy) overrun <= 1'b1;
   end

   // Combinational read port for the renderers.
   always_comb begin
      rd_x      = '0;
      rd_old_x  = '0;
      rd_y      = '0;
      rd_old_y  = '0;
      rd_active = 1'b0;
      rd_rate   = '0;
      if (int'(rd_idx) < NUM_BALLS) begin
         rd_x      = x_q[rd_idx];
         rd_old_x  = old_x_q[rd_idx];
         rd_y      = y_q[rd_idx];
         rd_old_y  = old_y_q[rd_idx];
         rd_active = active_q[rd_idx];
         rd_rate   = rate_q[rd_idx];
      end
   end

endmodule

// File: tb/tb_multi_ball_engine.sv
// Directed bench for multi_ball_engine with two balls and default playfield.
module tb_multi_ball_engine;

   localparam int NB = 2;
   localparam int IW = 1;
   localparam int XW = 11;
   localparam int YW = 10;
   localparam int RW = 5;

   logic          clk = 1'b0;
   logic          resetn;
   logic          enable;
   logic          frameTick;
   logic          serve;
   logic [IW-1:0] serve_idx;
   logic [1:0]    serve_dir;
   logic          serve_ready;
   logic [YW-1:0] left_paddle_y;
   logic [YW-1:0] right_paddle_y;
   logic [IW-1:0] rd_idx;
   logic [XW-1:0] rd_x, rd_old_x;
   logic [YW-1:0] rd_y, rd_old_y;
   logic          rd_active;
   logic [RW-1:0] rd_rate;
   logic          busy, update_done, overrun;
   logic          lhs_scored, rhs_scored, boundary_contact;
   logic [IW-1:0] event_idx;
   logic [1:0]    dbg_state;

   int n_vec = 0;
   int n_err = 0;

   // Captured during the most recent pass.
   int   t_lat;
   logic t_contact, t_lhs, t_rhs;
   logic [IW-1:0] t_eidx;
   int   n_done;

   multi_ball_engine #(.NUM_BALLS(NB)) dut (
      .clk(clk), .resetn(resetn), .enable(enable), .frameTick(frameTick),
      .serve(serve), .serve_idx(serve_idx), .serve_dir(serve_dir),
      .serve_ready(serve_ready), .left_paddle_y(left_paddle_y),
      .right_paddle_y(right_paddle_y), .rd_idx(rd_idx), .rd_x(rd_x),
      .rd_old_x(rd_old_x), .rd_y(rd_y), .rd_old_y(rd_old_y),
      .rd_active(rd_active), .rd_rate(rd_rate), .busy(busy),
      .update_done(update_done), .overrun(overrun), .lhs_scored(lhs_scored),
      .rhs_scored(rhs_scored), .boundary_contact(boundary_contact),
      .event_idx(event_idx), .dbg_state(dbg_state)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check_vec(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic read_ball(input int i);
      rd_idx = IW'(i);
      #1;
   endtask

   task automatic apply_reset();
      resetn = 1'b0;
      enable = 1'b0; frameTick = 1'b0; serve = 1'b0;
      serve_idx = '0; serve_dir = 2'b00;
      left_paddle_y = '0; right_paddle_y = '0; rd_idx = '0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
   endtask

   // One frame tick (optionally with a serve on the same clk); waits for update_done.
   task automatic do_tick(input logic srv, input logic [IW-1:0] sidx,
                          input logic [1:0] sdir);
      logic seen;
      seen = 1'b0;
      t_lat = 0; t_contact = 1'b0; t_lhs = 1'b0; t_rhs = 1'b0; t_eidx = '0;
      frameTick = 1'b1; serve = srv; serve_idx = sidx; serve_dir = sdir;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         frameTick = 1'b0; serve = 1'b0;
         if (boundary_contact) begin t_contact = 1'b1; t_eidx = event_idx; end
         if (lhs_scored)       begin t_lhs = 1'b1;     t_eidx = event_idx; end
         if (rhs_scored)       begin t_rhs = 1'b1;     t_eidx = event_idx; end
         if (update_done) begin seen = 1'b1; t_lat = c; break; end
      end
      if (!seen) check_vec("pass_timeout", 32'(seen), 32'd1);
      @(negedge clk);
   endtask

   task automatic tick_n(input int n);
      for (int k = 0; k < n; k++) do_tick(1'b0, '0, 2'b00);
   endtask

   // Paddles follow ball 0 so it is always returned.
   task automatic tick_track(input int n);
      for (int k = 0; k < n; k++) begin
         read_ball(0);
         left_paddle_y  = rd_y;
         right_paddle_y = rd_y;
         do_tick(1'b0, '0, 2'b00);
      end
   endtask

   initial begin
      apply_reset();
      resetn = 1'b0;
      @(negedge clk);
      // Reset state.
      check_vec("rst_busy", 32'(busy), 0);
      check_vec("rst_done", 32'(update_done), 0);
      check_vec("rst_overrun", 32'(overrun), 0);
      check_vec("rst_contact", 32'(boundary_contact), 0);
      check_vec("rst_lhs", 32'(lhs_scored), 0);
      check_vec("rst_rhs", 32'(rhs_scored), 0);
      for (int i = 0; i < NB; i++) begin
         read_ball(i);
         check_vec("rst_active", 32'(rd_active), 0);
         check_vec("rst_x", 32'(rd_x), 320);
         check_vec("rst_old_x", 32'(rd_old_x), 320);
         check_vec("rst_y", 32'(rd_y), 250);
         check_vec("rst_old_y", 32'(rd_old_y), 250);
         check_vec("rst_rate", 32'(rd_rate), 1);
      end
      resetn = 1'b1;
      @(negedge clk);
      enable = 1'b1;

      // Serve ball 0 right/down together with the first tick.
      do_tick(1'b1, 1'b0, 2'b11);
      check_vec("t1_latency", 32'(t_lat), 3);
      read_ball(0);
      check_vec("t1_x", 32'(rd_x), 321);
      check_vec("t1_y", 32'(rd_y), 251);
      check_vec("t1_old_x", 32'(rd_old_x), 320);
      check_vec("t1_old_y", 32'(rd_old_y), 250);
      check_vec("t1_active", 32'(rd_active), 1);
      read_ball(1);
      check_vec("t1_b1_idle", 32'(rd_active), 0);

      // Serve to an active ball is dropped.
      @(negedge clk);
      serve = 1'b1; serve_idx = 1'b0; serve_dir = 2'b00;
      @(negedge clk);
      serve = 1'b0;
      read_ball(0);
      check_vec("drop_x", 32'(rd_x), 321);
      check_vec("drop_y", 32'(rd_y), 251);
      do_tick(1'b0, '0, 2'b00);
      read_ball(0);
      check_vec("drop_dir_x", 32'(rd_x), 322);
      check_vec("drop_dir_y", 32'(rd_y), 252);

      // Serve while busy is ignored.
      frameTick = 1'b1;
      @(negedge clk);
      frameTick = 1'b0;
      check_vec("busy_ready", 32'(serve_ready), 0);
      serve = 1'b1; serve_idx = 1'b1; serve_dir = 2'b11;
      @(negedge clk);
      serve = 1'b0;
      repeat (4) @(negedge clk);
      read_ball(1);
      check_vec("busy_serve", 32'(rd_active), 0);
      read_ball(0);
      check_vec("t3_x", 32'(rd_x), 323);

      // enable low: tick and serve both ignored.
      enable = 1'b0;
      frameTick = 1'b1; serve = 1'b1; serve_idx = 1'b1; serve_dir = 2'b11;
      @(negedge clk);
      frameTick = 1'b0; serve = 1'b0;
      check_vec("dis_busy", 32'(busy), 0);
      read_ball(1);
      check_vec("dis_serve", 32'(rd_active), 0);
      enable = 1'b1;
      @(negedge clk);

      // Speed ramp and bottom wall on ball 0.
      tick_n(26);
      read_ball(0);
      check_vec("r29_rate", 32'(rd_rate), 1);
      check_vec("r29_x", 32'(rd_x), 349);
      tick_n(1);
      read_ball(0);
      check_vec("r30_rate", 32'(rd_rate), 2);
      check_vec("r30_y", 32'(rd_y), 280);
      tick_n(71);
      read_ball(0);
      check_vec("t101_y", 32'(rd_y), 474);
      check_vec("t101_x", 32'(rd_x), 544);
      check_vec("t101_rate", 32'(rd_rate), 4);
      do_tick(1'b0, '0, 2'b00);
      check_vec("wall_contact", 32'(t_contact), 1);
      check_vec("wall_eidx", 32'(t_eidx), 0);
      check_vec("wall_lhs", 32'(t_lhs), 0);
      read_ball(0);
      check_vec("wall_y", 32'(rd_y), 476);
      check_vec("wall_old_y", 32'(rd_old_y), 474);
      check_vec("wall_x", 32'(rd_x), 548);
      do_tick(1'b0, '0, 2'b00);
      check_vec("after_wall_contact", 32'(t_contact), 0);
      read_ball(0);
      check_vec("after_wall_y", 32'(rd_y), 472);

      // Right paddle miss.
      tick_n(20);
      read_ball(0);
      check_vec("t123_x", 32'(rd_x), 635);
      check_vec("t123_y", 32'(rd_y), 389);
      check_vec("t123_rate", 32'(rd_rate), 5);
      right_paddle_y = 10'd100;
      do_tick(1'b0, '0, 2'b00);
      check_vec("rmiss_lhs", 32'(t_lhs), 1);
      check_vec("rmiss_rhs", 32'(t_rhs), 0);
      check_vec("rmiss_contact", 32'(t_contact), 0);
      check_vec("rmiss_eidx", 32'(t_eidx), 0);
      read_ball(0);
      check_vec("rmiss_active", 32'(rd_active), 0);
      check_vec("rmiss_x", 32'(rd_x), 635);
      check_vec("rmiss_y", 32'(rd_y), 384);

      // enable low mid-pass freezes the pass.
      frameTick = 1'b1;
      @(negedge clk);
      frameTick = 1'b0;
      enable = 1'b0;
      repeat (3) @(negedge clk);
      check_vec("frz_busy", 32'(busy), 1);
      check_vec("frz_done", 32'(update_done), 0);
      check_vec("frz_state", 32'(dbg_state), 1);
      enable = 1'b1;
      t_lat = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (update_done) begin t_lat = c; break; end
      end
      check_vec("frz_resume", 32'(t_lat), 2);
      @(negedge clk);

      // Re-serve and ramp to the ceiling with tracking paddles.
      do_tick(1'b1, 1'b0, 2'b11);
      tick_track(28);
      read_ball(0);
      check_vec("rr29_rate", 32'(rd_rate), 1);
      tick_track(1);
      read_ball(0);
      check_vec("rr30_rate", 32'(rd_rate), 2);
      tick_track(389);
      read_ball(0);
      check_vec("rr419_rate", 32'(rd_rate), 14);
      tick_track(1);
      read_ball(0);
      check_vec("rr420_rate", 32'(rd_rate), 15);
      tick_track(40);
      read_ball(0);
      check_vec("rr460_rate", 32'(rd_rate), 15);
      check_vec("rr460_active", 32'(rd_active), 1);
      check_vec("no_overrun", 32'(overrun), 0);

      // Overrun: second tick at clk 1 of a pass.
      n_done = 0;
      frameTick = 1'b1;
      @(negedge clk);
      @(negedge clk);
      frameTick = 1'b0;
      if (update_done) n_done++;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (update_done) n_done++;
      end
      check_vec("ovr_flag", 32'(overrun), 1);
      check_vec("ovr_done_count", 32'(n_done), 1);

      // Reset mid-pass aborts everything immediately.
      read_ball(0);
      frameTick = 1'b1;
      @(negedge clk);
      frameTick = 1'b0;
      #2 resetn = 1'b0;
      #1;
      check_vec("arst_busy", 32'(busy), 0);
      check_vec("arst_done", 32'(update_done), 0);
      check_vec("arst_overrun", 32'(overrun), 0);
      check_vec("arst_contact", 32'(boundary_contact), 0);
      check_vec("arst_lhs", 32'(lhs_scored), 0);
      check_vec("arst_rhs", 32'(rhs_scored), 0);
      check_vec("arst_active", 32'(rd_active), 0);
      check_vec("arst_x", 32'(rd_x), 320);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      n_done = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (update_done) n_done++;
      end
      check_vec("arst_no_done", 32'(n_done), 0);

      // Left paddle hit on ball 1 (served left/up).
      apply_reset();
      enable = 1'b1;
      do_tick(1'b1, 1'b1, 2'b00);
      tick_n(121);
      read_ball(1);
      check_vec("b1_t122_x", 32'(rd_x), 10);
      check_vec("b1_t122_y", 32'(rd_y), 98);
      check_vec("b1_t122_rate", 32'(rd_rate), 5);
      left_paddle_y = 10'd90;
      do_tick(1'b0, '0, 2'b00);
      check_vec("lhit_latency", 32'(t_lat), 3);
      check_vec("lhit_contact", 32'(t_contact), 1);
      check_vec("lhit_eidx", 32'(t_eidx), 1);
      check_vec("lhit_rhs", 32'(t_rhs), 0);
      read_ball(1);
      check_vec("lhit_x", 32'(rd_x), 6);
      check_vec("lhit_y", 32'(rd_y), 103);
      check_vec("lhit_active", 32'(rd_active), 1);
      do_tick(1'b0, '0, 2'b00);
      read_ball(1);
      check_vec("lhit_dir_x", 32'(rd_x), 11);

      // Left paddle miss on the same trajectory.
      apply_reset();
      enable = 1'b1;
      do_tick(1'b1, 1'b1, 2'b00);
      tick_n(121);
      left_paddle_y = 10'd200;
      do_tick(1'b0, '0, 2'b00);
      check_vec("lmiss_rhs", 32'(t_rhs), 1);
      check_vec("lmiss_lhs", 32'(t_lhs), 0);
      check_vec("lmiss_contact", 32'(t_contact), 0);
      check_vec("lmiss_eidx", 32'(t_eidx), 1);
      read_ball(1);
      check_vec("lmiss_active", 32'(rd_active), 0);
      check_vec("lmiss_x", 32'(rd_x), 10);
      do_tick(1'b0, '0, 2'b00);
      check_vec("inactive_rhs", 32'(t_rhs), 0);
      check_vec("inactive_latency", 32'(t_lat), 3);
      read_ball(1);
      check_vec("inactive_x", 32'(rd_x), 10);
      check_vec("inactive_y", 32'(rd_y), 103);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
